// File: rtl/can_host_bus_master.sv
// Host-side bus initiator for the CAN controller register interface.
// Optional address range check is compiled in with `define CAN_HBM_ADDR_CHECK_EN.
module can_host_bus_master #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 31,
    parameter int CS_HOLD  = 3
) (
    input  logic              i_sys_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_rnw,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    output logic              o_cs,
    output logic              o_r_neg_w,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err
);

`ifdef CAN_HBM_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    localparam int CNT_W = $clog2(CS_HOLD);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              rnw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              accept;
    logic              addr_bad;
    logic              cmd_err;

    assign accept   = i_cmd_valid && (state == IDLE);
    assign addr_bad = {1'b0, i_cmd_addr} >= (ADDR_W+1)'(NUM_REGS);
    assign cmd_err  = ADDR_CHECK && addr_bad;

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_cmd_valid) state_nxt = cmd_err ? RESP : ACCESS;
            ACCESS:  if (cnt == '0) state_nxt = RESP;
            RESP:    if (i_rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // r_neg_w is forced low outside ACCESS so the downstream one-pulse logic re-arms
    always_comb begin
        o_cmd_ready = 1'b0;
        o_cs        = 1'b0;
        o_r_neg_w   = 1'b0;
        o_rsp_valid = 1'b0;
        case (state)
            IDLE:    o_cmd_ready = 1'b1;
            ACCESS:  begin
                o_cs      = 1'b1;
                o_r_neg_w = rnw_q;
            end
            RESP:    o_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            cnt     <= '0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            cnt     <= CNT_W'(CS_HOLD - 1);
            rnw_q   <= i_cmd_rnw;
            addr_q  <= i_cmd_addr;
            wdata_q <= i_cmd_wdata;
            rdata_q <= '0;
            err_q   <= cmd_err;
        end else if (state == ACCESS) begin
            if (cnt == '0) rdata_q <= rnw_q ? i_rdata : '0;
            else           cnt     <= cnt - 1'b1;
        end
    end

    assign o_addr      = addr_q;
    assign o_wdata     = wdata_q;
    assign o_rsp_rdata = rdata_q;
    assign o_rsp_err   = err_q;

endmodule

// File: tb/tb_can_host_bus_master.sv
// Randomized self-checking bench for can_host_bus_master against a
// transaction-level model (register memory + expected latency/cs length).
module tb_can_host_bus_master;
    localparam int ADDR_W = 5, DATA_W = 8, NUM_REGS = 31, CS_HOLD = 3;

    logic              i_sys_clk = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_cmd_valid = 1'b0;
    logic              o_cmd_ready;
    logic              i_cmd_rnw = 1'b0;
    logic [ADDR_W-1:0] i_cmd_addr = '0;
    logic [DATA_W-1:0] i_cmd_wdata = '0;
    logic              o_cs, o_r_neg_w;
    logic [ADDR_W-1:0] o_addr;
    logic [DATA_W-1:0] o_wdata;
    logic [DATA_W-1:0] i_rdata = '0;
    logic              o_rsp_valid;
    logic              i_rsp_ready = 1'b0;
    logic [DATA_W-1:0] o_rsp_rdata;
    logic              o_rsp_err;

    int checks = 0, errors = 0;
    logic [DATA_W-1:0] mem [0:31];

    // bus monitor state
    int cs_run = 0, low_run = 100, last_gap = 0;
    bit low_rnw_ok = 1'b1, last_low_ok = 1'b1;

    can_host_bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .CS_HOLD(CS_HOLD)) dut (
        .i_sys_clk(i_sys_clk), .i_reset(i_reset),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_rnw(i_cmd_rnw),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
        .o_cs(o_cs), .o_r_neg_w(o_r_neg_w), .o_addr(o_addr), .o_wdata(o_wdata),
        .i_rdata(i_rdata), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    // Register file model: read data is garbage until the 2nd select cycle.
    always @(negedge i_sys_clk) begin
        if (o_cs) begin
            if (cs_run == 0) begin
                last_gap    = low_run;
                last_low_ok = low_rnw_ok;
            end
            cs_run++;
            low_run    = 0;
            low_rnw_ok = 1'b1;
        end else begin
            cs_run = 0;
            low_run++;
            if (o_r_neg_w) low_rnw_ok = 1'b0;
        end
        i_rdata = (o_cs && o_r_neg_w && cs_run >= 2) ? mem[o_addr] : DATA_W'($urandom);
    end

    function automatic bit is_bad(input logic [ADDR_W-1:0] a);
`ifdef CAN_HBM_ADDR_CHECK_EN
        return int'(a) >= NUM_REGS;
`else
        return 1'b0;
`endif
    endfunction

    // Drives one command from a negedge and observes it until the response is taken.
    task automatic run_cmd(input logic rnw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                           input int stall, output int lat, output int cs_cnt, output bit stable,
                           output bit held, output logic [DATA_W-1:0] rd, output logic er,
                           output logic rdy);
        lat = -1; cs_cnt = 0; stable = 1'b1; held = 1'b1; rd = 'x; er = 1'bx;
        rdy = o_cmd_ready;
        i_cmd_valid = 1'b1; i_cmd_rnw = rnw; i_cmd_addr = a; i_cmd_wdata = wd;
        @(posedge i_sys_clk);
        @(negedge i_sys_clk);
        i_cmd_valid = 1'b0; i_cmd_rnw = ~rnw;
        i_cmd_addr = ADDR_W'($urandom); i_cmd_wdata = DATA_W'($urandom);
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            if (c > 1) @(negedge i_sys_clk);
            if (o_cs) begin
                cs_cnt++;
                if (o_addr !== a || o_wdata !== wd || o_r_neg_w !== rnw) stable = 1'b0;
            end
            if (o_rsp_valid) lat = c;
        end
        if (lat >= 0) begin
            rd = o_rsp_rdata; er = o_rsp_err;
            for (int s = 0; s < stall; s++) begin
                @(negedge i_sys_clk);
                if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== rd || o_rsp_err !== er || o_cs !== 1'b0)
                    held = 1'b0;
            end
            i_rsp_ready = 1'b1;
            @(posedge i_sys_clk);
            @(negedge i_sys_clk);
            i_rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (2) @(posedge i_sys_clk);
        @(negedge i_sys_clk);
        checks++;
        if ({o_cmd_ready, o_cs, o_r_neg_w, o_addr, o_wdata, o_rsp_valid, o_rsp_rdata, o_rsp_err}
            !== {1'b1, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got ready=%b cs=%b rnw=%b addr=%0d wd=%0h v=%b rd=%0h err=%b",
                     o_cmd_ready, o_cs, o_r_neg_w, o_addr, o_wdata, o_rsp_valid, o_rsp_rdata, o_rsp_err);
        end
        i_reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_sys_clk);
            checks++;
            if ({o_cs, o_rsp_valid, o_cmd_ready} !== 3'b001) begin
                errors++;
                $display("FAIL idle_cycle%0d got cs=%b v=%b ready=%b exp 0 0 1", i, o_cs, o_rsp_valid, o_cmd_ready);
            end
        end
    endtask

    task automatic test_write();
        int lat, cs_cnt; bit stable, held; logic [DATA_W-1:0] rd; logic er, rdy;
        run_cmd(1'b0, 5'd4, 8'hA5, 0, lat, cs_cnt, stable, held, rd, er, rdy);
        checks++;
        if (!(rdy === 1'b1 && lat == CS_HOLD + 1 && cs_cnt == CS_HOLD && stable)) begin
            errors++;
            $display("FAIL write_timing got rdy=%b lat=%0d cs=%0d stable=%0b exp 1 %0d %0d 1",
                     rdy, lat, cs_cnt, stable, CS_HOLD + 1, CS_HOLD);
        end
        checks++;
        if (rd !== 8'h00 || er !== 1'b0) begin
            errors++;
            $display("FAIL write_rsp got rdata=%0h err=%b exp 0 0", rd, er);
        end
    endtask

    task automatic test_read();
        int lat, cs_cnt; bit stable, held; logic [DATA_W-1:0] rd; logic er, rdy;
        mem[7] = 8'h3C;
        run_cmd(1'b1, 5'd7, 8'h00, 2, lat, cs_cnt, stable, held, rd, er, rdy);
        checks++;
        if (!(lat == CS_HOLD + 1 && cs_cnt == CS_HOLD && stable && held)) begin
            errors++;
            $display("FAIL read_timing got lat=%0d cs=%0d stable=%0b held=%0b", lat, cs_cnt, stable, held);
        end
        checks++;
        if (rd !== 8'h3C || er !== 1'b0) begin
            errors++;
            $display("FAIL read_rsp got rdata=%0h err=%b exp 3c 0", rd, er);
        end
    endtask

    task automatic test_back_to_back();
        int lat, cs_cnt; bit stable, held; logic [DATA_W-1:0] rd1, rd2; logic er, rdy;
        mem[1] = 8'h11; mem[2] = 8'h22;
        run_cmd(1'b1, 5'd1, 8'h00, 0, lat, cs_cnt, stable, held, rd1, er, rdy);
        run_cmd(1'b1, 5'd2, 8'h00, 0, lat, cs_cnt, stable, held, rd2, er, rdy);
        checks++;
        if (last_gap != 2 || !last_low_ok || rdy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap got gap=%0d rnw_low=%0b rdy=%b exp 2 1 1", last_gap, last_low_ok, rdy);
        end
        checks++;
        if (rd1 !== 8'h11 || rd2 !== 8'h22 || cs_cnt != CS_HOLD) begin
            errors++;
            $display("FAIL b2b_rsp got %0h %0h cs=%0d exp 11 22 %0d", rd1, rd2, cs_cnt, CS_HOLD);
        end
    endtask

    task automatic test_addr31();
        int lat, cs_cnt; bit stable, held; logic [DATA_W-1:0] rd; logic er, rdy;
        int exp_lat, exp_cs; logic [DATA_W-1:0] exp_rd;
        mem[31] = 8'h5A;
        exp_lat = is_bad(5'd31) ? 1 : CS_HOLD + 1;
        exp_cs  = is_bad(5'd31) ? 0 : CS_HOLD;
        exp_rd  = is_bad(5'd31) ? 8'h00 : mem[31];
        run_cmd(1'b1, 5'd31, 8'h00, 1, lat, cs_cnt, stable, held, rd, er, rdy);
        checks++;
        if (lat != exp_lat || cs_cnt != exp_cs || !held) begin
            errors++;
            $display("FAIL addr31_timing got lat=%0d cs=%0d held=%0b exp %0d %0d 1", lat, cs_cnt, held, exp_lat, exp_cs);
        end
        checks++;
        if (rd !== exp_rd || er !== is_bad(5'd31)) begin
            errors++;
            $display("FAIL addr31_rsp got rdata=%0h err=%b exp %0h %b", rd, er, exp_rd, is_bad(5'd31));
        end
    endtask

    task automatic test_random();
        int lat, cs_cnt; bit stable, held; logic [DATA_W-1:0] rd, exp_rd; logic er, rdy;
        logic rnw; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] wd; bit bad;
        for (int i = 0; i < 32; i++) mem[i] = DATA_W'($urandom);
        for (int n = 0; n < 40; n++) begin
            rnw = 1'($urandom); a = ADDR_W'($urandom); wd = DATA_W'($urandom);
            bad = is_bad(a);
            exp_rd = (rnw && !bad) ? mem[a] : 8'h00;
            run_cmd(rnw, a, wd, $urandom_range(0, 2), lat, cs_cnt, stable, held, rd, er, rdy);
            checks++;
            if (rdy !== 1'b1 || lat != (bad ? 1 : CS_HOLD + 1) || cs_cnt != (bad ? 0 : CS_HOLD) || !stable || !held) begin
                errors++;
                $display("FAIL rand%0d_timing rnw=%b a=%0d got rdy=%b lat=%0d cs=%0d stable=%0b held=%0b",
                         n, rnw, a, rdy, lat, cs_cnt, stable, held);
            end
            checks++;
            if (rd !== exp_rd || er !== bad) begin
                errors++;
                $display("FAIL rand%0d_rsp rnw=%b a=%0d got rdata=%0h err=%b exp %0h %b", n, rnw, a, rd, er, exp_rd, bad);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        int seen = 0, rsp_cnt = 0;
        i_cmd_valid = 1'b1; i_cmd_rnw = 1'b1; i_cmd_addr = 5'd5;
        @(posedge i_sys_clk);
        @(negedge i_sys_clk);
        i_cmd_valid = 1'b0;
        for (int c = 0; c < 10 && seen < 2; c++) begin
            if (c > 0) @(negedge i_sys_clk);
            if (o_cs) seen++;
        end
        checks++;
        if (seen != 2) begin
            errors++;
            $display("FAIL rst_mid_reach got cs_cycles=%0d exp 2", seen);
        end
        i_reset = 1'b1;
        @(posedge i_sys_clk);
        #1;
        checks++;
        if ({o_cs, o_rsp_valid, o_cmd_ready} !== 3'b001) begin
            errors++;
            $display("FAIL rst_mid_state got cs=%b v=%b ready=%b exp 0 0 1", o_cs, o_rsp_valid, o_cmd_ready);
        end
        @(negedge i_sys_clk);
        i_reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge i_sys_clk);
            if (o_rsp_valid || o_cs) rsp_cnt++;
        end
        checks++;
        if (rsp_cnt != 0) begin
            errors++;
            $display("FAIL rst_mid_no_rsp got busy_cycles=%0d exp 0", rsp_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_addr31();
        test_random();
        test_reset_mid_access();
        test_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
